// File: rtl/uart_stim_pkg.sv
// Shared types and constants for the stimulus UART transmitter.
// Holds the frame FSM state encoding and the frame-length helper.
package uart_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam int DATA_BITS = 8;

  // Total serial cycles of one frame: start + data + optional parity + stop bits.
  function automatic int frame_cycles(input int parity_en, input int stop_bits,
                                      input int clks_per_bit);
    return (1 + DATA_BITS + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// Byte FIFO feeding the stimulus transmitter; first-word fall-through read.
// Depth must be a power of two so the pointers wrap naturally.
module uart_stim_fifo
  import uart_stim_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst_pad_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_pad_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_stim_tx.sv
// Testbench-side UART transmitter driving the SoC receive pin with queued bytes.
// Frames are sent back-to-back while enabled; a started frame always completes.
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                         clk,
  input  logic                         rst_pad_i,
  input  logic                         enable,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         uart_tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
  localparam logic              PARITY_INV = (PARITY_ODD != 0);

  state_e                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   tx_q, tx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;

  logic                   fifo_push, fifo_pop;
  logic                   fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   baud_last, start_frame;

  assign fifo_push = in_valid && !fifo_full;

  uart_stim_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_pad_i (rst_pad_i),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (in_data),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_last ? '0 : baud_q + BAUD_ONE;
    bit_d       = bit_q;
    tx_d        = tx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d      = '0;
        bit_d       = '0;
        tx_d        = 1'b1;
        start_frame = 1'b1;
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_ONE;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            state_d     = ST_IDLE;
            bit_d       = '0;
            tx_d        = 1'b1;
            start_frame = 1'b1;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Shared by IDLE and the last stop cycle so consecutive frames have no gap.
    if (start_frame && !fifo_empty && enable) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dout;
      parity_d = (^fifo_dout) ^ PARITY_INV;
      state_d  = ST_START;
      baud_d   = '0;
      bit_d    = '0;
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_pad_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
    parity_q <= parity_d;
  end

  assign uart_tx    = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign in_ready   = !fifo_full;
  assign frame_done = (state_q == ST_STOP) && baud_last && (bit_q == STOP_LAST);

endmodule

// File: doc/uart_stim_tx.md
Name: uart_stim_tx

Overview:
- Testbench-side UART transmitter driving the SoC receive pin (uart0_srx_pad_i) with serial 8-bit frames.
- Replaces the current TX-to-RX loopback so tests inject arbitrary byte streams.
- Bytes arrive on a valid/ready push interface, are buffered in a small FIFO, and are serialised back-to-back at a fixed bit period.
- Sits directly upstream of the SoC UART0 receiver, alongside the existing UART0 decoder on the TX side.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (115200 baud at 100 MHz); legal range 2 and above.
- FIFO_DEPTH, 16, byte FIFO entries; must be a power of 2, 2 or more.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  sole clock.
- rst_pad_i  in  1  synchronous, active-low reset.
- enable  in  1  1 allows new frames to start; a frame in progress always completes.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  equals !fifo_full.
- uart_tx  out  1  serial output, idle high; registered.
- busy  out  1  1 in any state other than IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_done  out  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
Reset (rst_pad_i=0 at a rising edge) gives:
- uart_tx=1, busy=0, frame_done=0, fifo_level=0, in_ready=1.
- FSM=IDLE; baud and bit counters cleared.

Reset mid-frame:
- The frame is truncated and uart_tx returns high on that same edge.
- FIFO contents are discarded.

Push:
- A push is accepted on any edge where in_valid=1 and in_ready=1.
- When full (fifo_level=FIFO_DEPTH), in_ready=0 even if a pop happens in the same cycle; no overflow is possible.
- A push and a pop in the same cycle leave fifo_level unchanged.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO is non-empty and enable=1 at an edge, pop the head into the shift register, go to START, and drive uart_tx=0.
- START lasts CLKS_PER_BIT cycles, then DATA.
- DATA sends 8 bits LSB first, each CLKS_PER_BIT cycles. Then PARITY if PARITY_EN, else STOP.
- PARITY bit value: ^data XOR PARITY_ODD. Lasts CLKS_PER_BIT cycles, then STOP.
- STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- frame_done is asserted in the final STOP cycle.
- At that final edge: if FIFO is non-empty and enable=1, pop and go directly to START (no idle gap); otherwise go to IDLE.

Timing:
- Baud counter runs 0..CLKS_PER_BIT-1; a bit ends when the counter reaches CLKS_PER_BIT-1.
- Latency: a push accepted at edge N into an empty FIFO, while IDLE and enabled, gives uart_tx falling after edge N+1.
- Frame length is exactly (9+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.

enable:
- enable deasserted mid-frame has no effect on the current frame.
- It only blocks the next pop.

Decomposition:
- Package uart_stim_pkg holds:
  - the state enum typedef;
  - DATA_BITS=8;
  - function frame_cycles(parity_en, stop_bits, clks_per_bit).
- Sub-module uart_stim_fifo: synchronous FIFO with push, pop, din, dout, full, empty and level; reset shares clk/rst_pad_i.
- FSM, baud counter and shift register live in the top.

Test Plan (all scenarios use CLKS_PER_BIT=4 unless stated):
1. Push 0xA5 once -> uart_tx reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. Fall occurs 1 edge after acceptance. frame_done pulses at cycle 40 of the frame. busy=0 afterwards.
2. Push 0x00, 0xFF, 0x3C on consecutive cycles -> three frames with no idle gap between them. fifo_level goes 1,1,2 then decrements at each pop. frame_done pulses 3 times, 40 cycles apart.
3. FIFO_DEPTH=4, enable=0, push 5 bytes continuously -> in_ready=0 after the 4th accept and the 5th is held off. fifo_level=4. Raising enable starts transmission, and the 5th byte is accepted one cycle after the first pop.
4. PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, push 0x07 -> parity bit=1, then 2 stop bits. Frame is 48 cycles.
5. Assert rst_pad_i=0 in the middle of the DATA bits of 0x55 with 3 bytes queued -> on the next edge uart_tx=1, fifo_level=0, busy=0, and no frame_done pulse.
6. Deassert enable during the START bit with 1 byte queued behind -> the current frame completes normally. FSM enters IDLE, and the queued byte is sent only after enable returns to 1.
